// File: rtl/eq_cmp_bist.sv
// rtl/eq_cmp_bist.sv - exhaustive sweep-and-check BIST engine for a WIDTH-bit equality comparator
// Drives every {a,b} pair, samples aeqb after SETTLE cycles and accumulates mismatches.
module eq_cmp_bist #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic               aeqb,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt,
  output logic [2*WIDTH-1:0] first_fail
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [VW-1:0]   idx, idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [VW:0]     err_nx;
  logic [VW-1:0]   ff_nx;
  logic            pass_nx;
  logic            check;
  logic            mismatch;
  logic            last;

  // The operands are the two halves of the vector index, so {a,b} == idx always.
  assign a        = idx[VW-1:WIDTH];
  assign b        = idx[WIDTH-1:0];
  assign check    = (cnt == CW'(SETTLE));
  assign mismatch = check && (aeqb != (a == b));
  assign last     = &idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      err_cnt    <= err_nx;
      first_fail <= ff_nx;
      pass       <= pass_nx;
      busy       <= (state_nx == RUN);
      done       <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    err_nx   = err_cnt;
    ff_nx    = first_fail;
    pass_nx  = pass;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          idx_nx   = '0;
          cnt_nx   = '0;
          err_nx   = '0;
          ff_nx    = '0;
          pass_nx  = 1'b0;
        end
      end
      RUN: begin
        cnt_nx = cnt + 1'b1;
        if (check) begin
          cnt_nx = '0;
          if (mismatch) begin
            err_nx = err_cnt + 1'b1;
            if (err_cnt == '0) ff_nx = idx;
          end
          // The final vector finishes in place so a/b keep showing it afterwards.
          if (last) begin
            state_nx = DONE;
            pass_nx  = !mismatch && (err_cnt == '0);
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_eq_cmp_bist.sv
// tb/tb_eq_cmp_bist.sv - randomized and directed self-checking bench for eq_cmp_bist
// Two instances (SETTLE=1 and SETTLE=3) share clock and reset, each with its own faultable comparator.
module tb_eq_cmp_bist;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [1:0] av [2];
  logic [1:0] bv [2];
  logic [1:0] aeqb_v;
  logic [1:0] busy_v, done_v, pass_v;
  logic [4:0] err_v [2];
  logic [3:0] ff_v [2];

  int total = 0;
  int bad = 0;

  int mode [2] = '{0, 0};
  int tv [2] = '{0, 0};
  int dly [2] = '{0, 0};
  int sv [2] = '{1, 3};

  always #5 clk = ~clk;

  eq_cmp_bist #(.WIDTH(2), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(av[0]), .b(bv[0]), .aeqb(aeqb_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]), .first_fail(ff_v[0])
  );

  eq_cmp_bist #(.WIDTH(2), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(av[1]), .b(bv[1]), .aeqb(aeqb_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]), .first_fail(ff_v[1])
  );

  // Comparator under test: 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 golden inverted at vector t.
  function automatic logic fmode(int m, int t, int v);
    logic eq;
    eq = ((v >> 2) == (v & 3));
    case (m)
      1: return 1'b0;
      2: return 1'b1;
      3: return (v == t) ? !eq : eq;
      default: return eq;
    endcase
  endfunction

  logic [3:0] pipe0 = 4'hf;
  logic [3:0] pipe1 = 4'hf;
  always @(posedge clk) begin
    pipe0 <= {pipe0[2:0], fmode(mode[0], tv[0], int'({av[0], bv[0]}))};
    pipe1 <= {pipe1[2:0], fmode(mode[1], tv[1], int'({av[1], bv[1]}))};
  end
  always_comb begin
    aeqb_v[0] = (dly[0] == 0) ? fmode(mode[0], tv[0], int'({av[0], bv[0]})) : pipe0[2'(dly[0] - 1)];
    aeqb_v[1] = (dly[1] == 0) ? fmode(mode[1], tv[1], int'({av[1], bv[1]})) : pipe1[2'(dly[1] - 1)];
  end

  // Reference model: k counts edges since the accepting edge; fl[v] says whether vector v is seen wrong.
  int k [2] = '{999, 999};
  bit fresh [2] = '{1'b1, 1'b1};
  bit fl [2][16];

  function automatic int span(int i);
    return N * (sv[i] + 1);
  endfunction

  task automatic accept(int i);
    int s, c, j, vec, prevv;
    s = sv[i];
    prevv = fresh[i] ? 0 : N - 1;
    for (int v = 0; v < N; v++) begin
      c = (v + 1) * (s + 1) - 1;
      j = c - dly[i];
      vec = (j >= 0) ? j / (s + 1) : prevv;
      fl[i][v] = (fmode(mode[i], tv[i], vec) != ((v >> 2) == (v & 3)));
    end
    k[i] = 0;
    fresh[i] = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        fresh[i] = 1'b1;
        k[i] = span(i) + 1;
      end else if (k[i] > span(i) && start[i]) begin
        accept(i);
      end else if (k[i] <= span(i)) begin
        k[i] = k[i] + 1;
      end
    end
  end

  task automatic expect_out(int i, output int eb, output int ed, output int evec,
                            output int eerr, output int eff, output int ep);
    int s, l;
    s = sv[i];
    l = span(i);
    eb = 0; ed = 0; evec = 0; eerr = 0; eff = 0; ep = 0;
    if (!fresh[i]) begin
      for (int v = 0; v < N; v++) begin
        if (fl[i][v] && (v + 1) * (s + 1) <= k[i]) begin
          if (eerr == 0) eff = v;
          eerr++;
        end
      end
      eb = (k[i] < l) ? 1 : 0;
      ed = (k[i] == l) ? 1 : 0;
      evec = (k[i] < l) ? k[i] / (s + 1) : N - 1;
      ep = (k[i] >= l && eerr == 0) ? 1 : 0;
    end
  endtask

  task automatic cmp(string nm, int i, logic [31:0] act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int eb, ed, evec, eerr, eff, ep;
    for (int i = 0; i < 2; i++) begin
      expect_out(i, eb, ed, evec, eerr, eff, ep);
      cmp("busy", i, 32'(busy_v[i]), eb);
      cmp("done", i, 32'(done_v[i]), ed);
      cmp("ab", i, 32'({av[i], bv[i]}), evec);
      cmp("err_cnt", i, 32'(err_v[i]), eerr);
      cmp("first_fail", i, 32'(ff_v[i]), eff);
      cmp("pass", i, 32'(pass_v[i]), ep);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic int model_err(int i);
    int e = 0;
    for (int v = 0; v < N; v++) if (fl[i][v]) e++;
    return e;
  endfunction

  // Launch a sweep and follow it to done; n is the edge count (from the accepting edge) at done.
  task automatic sweep(int i, int m, int t, int d, int pulse_at, output int n, output int nb);
    mode[i] = m; tv[i] = t; dly[i] = d;
    tick(6);
    start[i] = 1'b1;
    tick(1);
    start[i] = 1'b0;
    n = 0; nb = 0;
    while (!done_v[i] && n < 300) begin
      if (busy_v[i]) nb++;
      tick(1);
      n++;
      start[i] = (n == pulse_at);
    end
    start[i] = 1'b0;
    if (n >= 300) cmp("done_timeout", i, 32'(n), 0);
  endtask

  initial begin
    int n, nb, nd, i, m, t, d, p;
    tick(3);
    cmp("reset_busy", 0, 32'(busy_v), 0);
    cmp("reset_err", 0, 32'(err_v[0]), 0);
    rst_n = 1'b1;
    tick(2);

    sweep(0, 0, 0, 0, -1, n, nb);
    cmp("t1_done_edge", 0, 32'(n), 32);
    cmp("t1_busy_cycles", 0, 32'(nb), 32);
    cmp("t1_pass", 0, 32'(pass_v[0]), 1);
    cmp("t1_ab", 0, 32'({av[0], bv[0]}), 15);
    cmp("t1_model_err", 0, 32'(model_err(0)), 0);

    sweep(0, 1, 0, 0, -1, n, nb);
    cmp("t2_err", 0, 32'(err_v[0]), 4);
    cmp("t2_ff", 0, 32'(ff_v[0]), 0);
    cmp("t2_pass", 0, 32'(pass_v[0]), 0);
    cmp("t2_model_err", 0, 32'(model_err(0)), 4);

    sweep(0, 2, 0, 0, -1, n, nb);
    cmp("t3_err", 0, 32'(err_v[0]), 12);
    cmp("t3_ff", 0, 32'(ff_v[0]), 1);
    cmp("t3_model_err", 0, 32'(model_err(0)), 12);

    sweep(0, 3, 10, 0, -1, n, nb);
    cmp("t4_err", 0, 32'(err_v[0]), 1);
    cmp("t4_ff", 0, 32'(ff_v[0]), 10);
    cmp("t4_pass", 0, 32'(pass_v[0]), 0);

    sweep(0, 0, 0, 0, 5, n, nb);
    cmp("t5_ignored_start_edge", 0, 32'(n), 32);
    cmp("t5_pass", 0, 32'(pass_v[0]), 1);

    mode[0] = 2;
    tick(6);
    start[0] = 1'b1;
    tick(10);
    start[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    cmp("t5_rst_busy", 0, 32'(busy_v[0]), 0);
    cmp("t5_rst_err", 0, 32'(err_v[0]), 0);
    cmp("t5_rst_ab", 0, 32'({av[0], bv[0]}), 0);
    tick(2);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (done_v[0]) nd++;
    end
    cmp("t5_no_done_after_abort", 0, 32'(nd), 0);
    sweep(0, 0, 0, 0, -1, n, nb);
    cmp("t5_clean_edge", 0, 32'(n), 32);
    cmp("t5_clean_pass", 0, 32'(pass_v[0]), 1);

    // start held high through DONE is accepted two edges after done.
    tick(3);
    start[0] = 1'b1;
    tick(33);
    cmp("rearm_done", 0, 32'(done_v[0]), 1);
    tick(1);
    cmp("rearm_idle", 0, 32'(busy_v[0]), 0);
    tick(1);
    cmp("rearm_busy", 0, 32'(busy_v[0]), 1);
    start[0] = 1'b0;
    tick(40);

    sweep(1, 0, 0, 3, -1, n, nb);
    cmp("t6_done_edge", 1, 32'(n), 64);
    cmp("t6_pass", 1, 32'(pass_v[1]), 1);
    sweep(1, 0, 0, 4, -1, n, nb);
    cmp("t6_slow_pass", 1, 32'(pass_v[1]), 0);
    cmp("t6_slow_err", 1, 32'(err_v[1]), 6);
    cmp("t6_slow_ff", 1, 32'(ff_v[1]), 1);

    for (int r = 0; r < 16; r++) begin
      i = $urandom_range(0, 1);
      m = $urandom_range(0, 3);
      t = $urandom_range(0, 15);
      d = $urandom_range(0, (i == 1) ? 4 : 2);
      p = ($urandom_range(0, 1) == 1) ? $urandom_range(1, span(i) - 3) : -1;
      sweep(i, m, t, d, p, n, nb);
      cmp("rand_done_edge", i, 32'(n), span(i));
      tick($urandom_range(0, 4));
    end

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eq_cmp_bist.md
Name: eq_cmp_bist

Overview:
Self-checking stimulus engine for the WIDTH-bit equality comparator (eq2 family). It is the driving and checking end of the comparator's a/b/aeqb interface. It sweeps every {a,b} operand pair, waits a programmable settle time, samples aeqb and compares it with an internal a==b reference. It then reports the mismatch count, the first failing vector and pass/fail, for on-chip BIST or FPGA bring-up.

Parameters:
WIDTH, 2, operand width per side; total vectors N = 2^(2*WIDTH)
SETTLE, 1, clock cycles (≥1) allowed for the comparator output to settle before sampling

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled request to run one full sweep
a  output  WIDTH  operand A to comparator under test (registered)
b  output  WIDTH  operand B to comparator under test (registered)
aeqb  input  1  comparator result under test
busy  output  1  high while a sweep is running
done  output  1  one-cycle pulse at sweep end
pass  output  1  1 = last sweep had zero mismatches; held until next start
err_cnt  output  2*WIDTH+1  mismatch count of last or current sweep
first_fail  output  2*WIDTH  {a,b} of first mismatching vector; 0 if none

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0; internal idx=0, settle cnt=0. Reset mid-sweep aborts immediately with no done pulse.
- Registered states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle, busy=0.
- IDLE→RUN on an edge with start=1. On that edge: idx=0, cnt=0, err_cnt=0, first_fail=0, pass=0, {a,b}=0.
- start is ignored in RUN and DONE. No queuing.
- RUN: {a,b} always equals idx.
  - cnt increments each cycle.
  - On the edge where cnt==SETTLE, aeqb is sampled; expected value = (a==b).
  - On a mismatch: err_cnt+1. If err_cnt was 0 before the edge, first_fail=idx.
  - On the same edge: cnt=0 and idx+1, so the new vector appears immediately.
- Each vector is held for SETTLE+1 cycles. A comparator path with up to SETTLE register stages passes.
- Last vector (idx = all ones) is sampled on its check edge, then RUN→DONE. idx does not wrap. pass = (err_cnt including the last check == 0). a/b hold the last vector.
- DONE→IDLE on the next edge. The outputs a, b, err_cnt, first_fail and pass hold until the next start or reset.
- Timing: done is high in the cycle after edge N*(SETTLE+1), counted from the start-accepting edge (edge 0).
- err_cnt width holds N without overflow. No saturation is needed.
- start held high through DONE re-arms on the edge leaving DONE→IDLE. IDLE then accepts it on the following edge.

Test Plan:
1. WIDTH=2, SETTLE=1, aeqb from a golden combinational a==b; one start pulse → busy for 32 cycles, done pulse after edge 32, pass=1, err_cnt=0, first_fail=0, a/b=2'b11/2'b11.
2. aeqb stuck at 0 → err_cnt=4, first_fail=4'b0000, pass=0.
3. aeqb stuck at 1 → err_cnt=12, first_fail=4'b0001, pass=0.
4. Golden model with output inverted only for a=2'b10, b=2'b10 → err_cnt=1, first_fail=4'b1010, pass=0.
5. start pulsed again at cycle 5 (ignored: sweep still ends at edge 32). Then restart, and drive rst_n=0 at cycle 10 → all outputs 0 immediately, no done. A following start gives a clean 32-cycle sweep with pass=1.
6. SETTLE=3, golden model delayed by 3 registers → done after edge 64, pass=1. Same with a 4-register delay → pass=0, err_cnt>0.
